sync_reg_reader: RTL and testbench
==================================

Name: sync_reg_reader

Overview:
- Read-domain consumer for the clock-domain-crossing sync register; runs entirely on the read clock.
- Watches the register's r_empty/r_data outputs and debounces the "data present" indication.
- Captures each new word, acknowledges it back to the register with a one-cycle r_rd strobe, and buffers words in a small FIFO.
- Presents buffered words to downstream logic over a valid/ready handshake.

Parameters:
SIZE, 8, data word width in bits.
DEPTH, 4, output FIFO entries; power of two, minimum 2.
SETTLE_CYCLES, 2, consecutive r_empty=0 samples required before capture; 0 allowed.

Ports:
r_clk  in  1  single clock, read domain; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
r_data  in  SIZE  word from sync register; valid while r_empty=0.
r_empty  in  1  1 = no word pending; 0 = word pending.
r_rd  out  1  one-cycle consume strobe to sync register.
out_data  out  SIZE  head-of-FIFO word.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  downstream accepts out_data when out_valid & out_ready.
overrun  out  1  sticky; a word was dropped because the FIFO was full.
fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are r_clk and rst.
- Reset (rst=1 at an edge):
  - state=IDLE, settle counter=0, FIFO pointers=0.
  - r_rd=0, out_valid=0, out_data=0, overrun=0, fifo_level=0.
  - rst overrides all other inputs, including mid-SETTLE and mid-CAPTURE; a partially settled word is discarded.
- FSM:
  - IDLE: r_empty=0 -> SETTLE with counter=1. If SETTLE_CYCLES=0, go directly to CAPTURE instead.
  - SETTLE: r_empty=1 -> IDLE (glitch rejected, no r_rd). Otherwise counter++; counter==SETTLE_CYCLES -> CAPTURE.
  - CAPTURE (exactly 1 cycle):
    - r_rd=1 (combinational from state).
    - r_data is pushed into the FIFO at the end of the cycle if there is space.
    - Always -> WAIT_EMPTY.
  - WAIT_EMPTY: r_rd=0; r_empty=1 -> IDLE. Re-arms only after r_empty has returned high, so one word gives exactly one capture.
- Latency: with first r_empty=0 sample at edge E, r_rd is high in the cycle after edge E+SETTLE_CYCLES and out_valid rises at edge E+SETTLE_CYCLES+1. Default is 3 edges.
- FIFO:
  - Read/write pointers are clog2(DEPTH)+1 bits wide; the extra bit distinguishes full from empty; pointers wrap modulo 2*DEPTH.
  - out_data = mem[rd_ptr] (registered memory, combinational head read).
  - out_data holds its last value when the FIFO is empty.
  - Pop occurs when out_valid & out_ready.
- Boundary cases:
  - Full and no pop in the CAPTURE cycle: word dropped, overrun<=1, r_rd still asserted so the register is not left stalled.
  - Full with a simultaneous pop in the CAPTURE cycle: push accepted, level unchanged, no overrun.
  - Empty FIFO: out_ready is ignored and pointers do not move.
  - overrun clears only on rst.
- fifo_level = wr_ptr - rd_ptr, width clog2(DEPTH)+1, never exceeds DEPTH.

Optional Feature:
- Macro: SYNC_READER_STATS_EN.
- When defined:
  - Extra output cap_count [15:0] counts accepted captures and wraps 0xFFFF->0.
  - Extra output drop_count [7:0] counts dropped words and saturates at 0xFF.
  - Both counters reset to 0 on rst.
- When undefined: neither port exists and neither counter is synthesised; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 3 edges with r_empty=0 -> r_rd=0, out_valid=0, overrun=0, fifo_level=0 throughout; capture sequence starts only after rst deasserts.
- Single word: r_data=8'hBB, r_empty falls at edge E, out_ready=0 -> r_rd one cycle after E+2, out_valid=1 at E+3 with out_data=8'hBB, fifo_level=1; raise out_ready -> level 0 next edge.
- Glitch rejection: r_empty low for 1 cycle only (SETTLE_CYCLES=2) -> no r_rd, FIFO stays empty, FSM back in IDLE.
- Overrun: out_ready=0, deliver 5 words 8'h01..8'h05 -> first 4 stored, 5th dropped, r_rd pulsed 5 times, overrun=1; drain -> 01,02,03,04 in order; 8'h05 never appears.
- Full with simultaneous pop: FIFO full (01..04), out_ready=1 during CAPTURE of 8'h05 -> level stays 4, overrun=0, drained order 02,03,04,05.
- Reset mid-operation: assert rst during SETTLE -> no r_rd; after release with r_empty still 0 the full SETTLE_CYCLES count restarts before capture.

Source files
------------

// File: rtl/sync_reg_reader_if.sv
// Bundles the sync-register read port and the downstream valid/ready port of sync_reg_reader.
// The master modport is the reader's view and the slave modport is the environment's view.
interface sync_reg_reader_if #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4
);
  logic [SIZE-1:0]        r_data;
  logic                   r_empty;
  logic                   r_rd;
  logic [SIZE-1:0]        out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   overrun;
  logic [$clog2(DEPTH):0] fifo_level;

  modport master (
    input  r_data, r_empty, out_ready,
    output r_rd, out_data, out_valid, overrun, fifo_level
  );

  modport slave (
    output r_data, r_empty, out_ready,
    input  r_rd, out_data, out_valid, overrun, fifo_level
  );
endinterface

// File: rtl/sync_reg_reader.sv
// Read-domain consumer for the CDC sync register: debounce, capture with one-cycle r_rd ack, FIFO, valid/ready out.
// Defining SYNC_READER_STATS_EN adds cap_count/drop_count outputs.
module sync_reg_reader #(
  parameter int SIZE          = 8,
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              r_clk,
  input  logic              rst,
  sync_reg_reader_if.master bus
`ifdef SYNC_READER_STATS_EN
  ,
  output logic [15:0]       cap_count,
  output logic [7:0]        drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(SETTLE_CYCLES + 2);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] SETTLE     = 2'd1;
  localparam logic [1:0] CAPTURE    = 2'd2;
  localparam logic [1:0] WAIT_EMPTY = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   level;
  logic [SIZE-1:0] last_data;
  logic            overrun_q;
  logic            capture;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  assign capture = (state == CAPTURE);
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == PW'(DEPTH));
  assign pop     = !empty && bus.out_ready;
  // A pop in the same cycle frees the slot the capture needs.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_ff @(posedge r_clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.r_empty) begin
            if (SETTLE_CYCLES == 0) begin
              state <= CAPTURE;
            end else begin
              state <= SETTLE;
              cnt   <= CW'(1);
            end
          end
        end
        SETTLE: begin
          if (bus.r_empty) begin
            state <= IDLE;
          end else if (cnt == CW'(SETTLE_CYCLES)) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CAPTURE: state <= WAIT_EMPTY;
        default: begin
          if (bus.r_empty) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge r_clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_data <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= bus.r_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) begin
        last_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr    <= rd_ptr + PW'(1);
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign bus.r_rd       = capture;
  assign bus.out_valid  = !empty;
  // When drained, keep showing the word that was last handed downstream.
  assign bus.out_data   = empty ? last_data : mem[rd_ptr[AW-1:0]];
  assign bus.overrun    = overrun_q;
  assign bus.fifo_level = level;

`ifdef SYNC_READER_STATS_EN
  always_ff @(posedge r_clk) begin
    if (rst) begin
      cap_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        cap_count <= cap_count + 16'd1;
      end
      if (drop && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_sync_reg_reader.sv
// Directed bench for sync_reg_reader: table-driven overrun vectors plus hand sequences for latency, glitch, pop-on-full and reset.
module tb_sync_reg_reader;
  localparam int SIZE  = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] data;
    int         level;
    logic       ovr;
  } vec_t;

  logic r_clk = 1'b0;
  logic rst   = 1'b1;
  int   checks    = 0;
  int   errors    = 0;
  int   rd_pulses = 0;

  sync_reg_reader_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

`ifdef SYNC_READER_STATS_EN
  logic [15:0] cap_count;
  logic [7:0]  drop_count;
`endif

  sync_reg_reader #(.SIZE(SIZE), .DEPTH(DEPTH), .SETTLE_CYCLES(2)) dut (
    .r_clk      (r_clk),
    .rst        (rst),
    .bus        (bus.master)
`ifdef SYNC_READER_STATS_EN
    ,
    .cap_count  (cap_count),
    .drop_count (drop_count)
`endif
  );

  always #5 r_clk = ~r_clk;

  // Counts cycles in which r_rd was high (value before the edge).
  always @(posedge r_clk) if (bus.r_rd === 1'b1) rd_pulses++;

  task automatic tick();
    @(negedge r_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.r_empty = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Models the sync register: present a word, drop r_empty, clear it once r_rd is seen.
  task automatic deliver(input logic [7:0] d, input logic rdy_at_cap, output int lat);
    lat = -1;
    bus.r_data  = d;
    bus.r_empty = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.r_rd === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("deliver_rd_seen", 32'(lat > 0), 32'd1);
    bus.out_ready = rdy_at_cap;
    bus.r_empty   = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
  endtask

  task automatic pop_check(input logic [7:0] exp);
    check("pop_valid", 32'(bus.out_valid), 32'd1);
    check("pop_data", 32'(bus.out_data), 32'(exp));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs [5];
    int   lat;
    int   base;

    vecs[0] = '{8'h01, 1, 1'b0};
    vecs[1] = '{8'h02, 2, 1'b0};
    vecs[2] = '{8'h03, 3, 1'b0};
    vecs[3] = '{8'h04, 4, 1'b0};
    vecs[4] = '{8'h05, 4, 1'b1};

    // Reset held for 3 edges while a word is pending.
    bus.r_data    = 8'hA5;
    bus.r_empty   = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rd", 32'(bus.r_rd), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      check("rst_level", 32'(bus.fifo_level), 32'd0);
    end
    check("rst_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;
    tick();
    check("rel_rd_e0", 32'(bus.r_rd), 32'd0);
    tick();
    check("rel_rd_e1", 32'(bus.r_rd), 32'd0);
    tick();
    check("rel_rd_e2", 32'(bus.r_rd), 32'd1);
    bus.r_empty = 1'b1;
    tick();
    tick();
    check("rel_level", 32'(bus.fifo_level), 32'd1);
    pop_check(8'hA5);

    // Single word latency and hold-after-drain.
    bus.r_data  = 8'hBB;
    bus.r_empty = 1'b0;
    tick();
    check("sw_rd_e0", 32'(bus.r_rd), 32'd0);
    tick();
    check("sw_rd_e1", 32'(bus.r_rd), 32'd0);
    tick();
    check("sw_rd_e2", 32'(bus.r_rd), 32'd1);
    check("sw_valid_e2", 32'(bus.out_valid), 32'd0);
    bus.r_empty = 1'b1;
    tick();
    check("sw_rd_e3", 32'(bus.r_rd), 32'd0);
    check("sw_valid_e3", 32'(bus.out_valid), 32'd1);
    check("sw_data_e3", 32'(bus.out_data), 32'hBB);
    check("sw_level_e3", 32'(bus.fifo_level), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("sw_level_pop", 32'(bus.fifo_level), 32'd0);
    check("sw_valid_pop", 32'(bus.out_valid), 32'd0);
    check("sw_data_hold", 32'(bus.out_data), 32'hBB);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("empty_ready_ignored", 32'(bus.fifo_level), 32'd0);

    // Glitch: one low sample of r_empty must not capture.
    base = rd_pulses;
    bus.r_data  = 8'hEE;
    bus.r_empty = 1'b0;
    tick();
    bus.r_empty = 1'b1;
    tick();
    tick();
    tick();
    check("glitch_no_rd", 32'(rd_pulses - base), 32'd0);
    check("glitch_level", 32'(bus.fifo_level), 32'd0);
    deliver(8'h3C, 1'b0, lat);
    check("glitch_then_lat", 32'(lat), 32'd3);
    check("glitch_then_level", 32'(bus.fifo_level), 32'd1);
    pop_check(8'h3C);

    // Overrun: five words into a four-entry FIFO with no draining.
    do_reset();
    base = rd_pulses;
    for (int i = 0; i < 5; i++) begin
      deliver(vecs[i].data, 1'b0, lat);
      check("ovr_level", 32'(bus.fifo_level), 32'(vecs[i].level));
      check("ovr_flag", 32'(bus.overrun), 32'(vecs[i].ovr));
    end
    check("ovr_rd_pulses", 32'(rd_pulses - base), 32'd5);
    for (int i = 0; i < 4; i++) pop_check(vecs[i].data);
    check("ovr_drained", 32'(bus.out_valid), 32'd0);
    check("ovr_sticky", 32'(bus.overrun), 32'd1);

    // Full with a pop in the capture cycle.
    do_reset();
    check("pf_ovr_cleared", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < 4; i++) deliver(vecs[i].data, 1'b0, lat);
    deliver(8'h05, 1'b1, lat);
    check("pf_level", 32'(bus.fifo_level), 32'd4);
    check("pf_overrun", 32'(bus.overrun), 32'd0);
    pop_check(8'h02);
    pop_check(8'h03);
    pop_check(8'h04);
    pop_check(8'h05);
    check("pf_drained", 32'(bus.out_valid), 32'd0);

    // Reset during SETTLE restarts the full debounce.
    do_reset();
    base = rd_pulses;
    bus.r_data  = 8'h77;
    bus.r_empty = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_rd", 32'(bus.r_rd), 32'd0);
    rst = 1'b0;
    tick();
    check("mid_rd_e0", 32'(bus.r_rd), 32'd0);
    tick();
    check("mid_rd_e1", 32'(bus.r_rd), 32'd0);
    tick();
    check("mid_rd_e2", 32'(bus.r_rd), 32'd1);
    bus.r_empty = 1'b1;
    tick();
    tick();
    check("mid_rd_pulses", 32'(rd_pulses - base), 32'd1);
    check("mid_level", 32'(bus.fifo_level), 32'd1);
    check("mid_data", 32'(bus.out_data), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
